// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern, decoder FSM
// states and the pattern-to-hex decode function.
package seg_pkg;

    // Segment patterns are packed {g,f,e,d,c,b,a}; all-off is the blank glyph.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } seg_state_t;

    // Returns {hit, hex}; hit is 0 and hex is 0 when pat is not a glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        res = 5'h00;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_GLYPH[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_sync2.sv
// Two-flop synchronizer for the seven segment lines, which arrive
// asynchronously to clk.
module seg_sync2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] d,
    output logic [6:0] q
);

    logic [6:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 7'h00;
            q    <= 7'h00;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Decodes settled seven-segment line patterns back to a hex value.
// Define SEG_ACTIVE_LOW_EN for common-anode (active-low) segment lines.
module seg_pattern_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] hex,
    output logic       known,
    output logic       blank,
    output logic       upd,
    output seg_state_t state_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       pat;
    logic [6:0]       s;
    logic [6:0]       cand;
    logic [6:0]       committed;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       dec;
    seg_state_t       state;

`ifdef SEG_ACTIVE_LOW_EN
    assign pat = ~{g, f, e, d, c, b, a};
`else
    assign pat = {g, f, e, d, c, b, a};
`endif

    seg_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pat),
        .q     (s)
    );

    assign dec       = seg_decode(cand);
    assign state_dbg = state;

    // upd is a valid-only strobe: high for exactly the one cycle spent in
    // COMMIT, with hex/known/blank already carrying the new value; there is
    // no ready, the consumer must take it in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= SEG_BLANK;
            committed <= SEG_BLANK;
            cnt       <= '0;
            hex       <= 4'h0;
            known     <= 1'b0;
            blank     <= 1'b1;
            upd       <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (s != committed) begin
                        cand  <= s;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (s != cand) begin
                        cand <= s;
                        cnt  <= '0;
                    end else if (cnt == CNT_MAX) begin
                        cnt <= '0;
                        // Settling back onto the committed glyph is not an update.
                        if (cand == committed) begin
                            state <= IDLE;
                        end else begin
                            committed <= cand;
                            upd       <= 1'b1;
                            state     <= COMMIT;
                            if (dec[4]) begin
                                hex   <= dec[3:0];
                                known <= 1'b1;
                                blank <= 1'b0;
                            end else begin
                                known <= 1'b0;
                                blank <= (cand == SEG_BLANK);
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder: vector table plus hand-written
// reset sequences, with a scoreboard of expected commit values.
module tb_seg_pattern_decoder;
    import seg_pkg::*;

    localparam int STABLE  = 16;
    localparam int UPD_CYC = STABLE + 3;
`ifdef SEG_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c, d, e, f, g;
    logic [3:0] hex;
    logic       known, blank, upd;
    seg_state_t state_dbg;

    typedef struct {
        logic [6:0] pat;
        int         hold;
        int         n_upd;
        logic [3:0] hex;
        logic       known;
        logic       blank;
    } vec_t;

    vec_t       vecs [12];
    logic [5:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    seg_pattern_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .hex       (hex),
        .known     (known),
        .blank     (blank),
        .upd       (upd),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: p is the logical pattern {g,f,e,d,c,b,a}
    task automatic set_pat(input logic [6:0] p);
        logic [6:0] raw;
        raw = p ^ {7{INV}};
        {g, f, e, d, c, b, a} = raw;
    endtask

    // scoreboard: each upd must match the next queued {known, blank, hex}
    task automatic sb_pop();
        logic [5:0] exp;
        if (exp_q.size() == 0) begin
            check("unexpected_upd", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check("upd_outputs", {26'd0, known, blank, hex}, {26'd0, exp});
        end
    endtask

    task automatic run_cycles(input int n, output int n_upd, output int first);
        n_upd = 0;
        first = -1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (upd) begin
                n_upd++;
                if (first < 0) first = k;
                sb_pop();
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hex"},   32'(hex),   32'd0);
        check({tag, "_known"}, 32'(known), 32'd0);
        check({tag, "_blank"}, 32'(blank), 32'd1);
        check({tag, "_upd"},   32'(upd),   32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        int n_upd, first;

        vecs[0]  = '{7'h5B, 30, 1, 4'h2, 1'b1, 1'b0};
        vecs[1]  = '{7'h06, 10, 0, 4'h2, 1'b1, 1'b0};
        vecs[2]  = '{7'h5B, 30, 0, 4'h2, 1'b1, 1'b0};
        vecs[3]  = '{7'h7F,  5, 0, 4'h2, 1'b1, 1'b0};
        vecs[4]  = '{7'h6F, 30, 1, 4'h9, 1'b1, 1'b0};
        vecs[5]  = '{7'h49, 30, 1, 4'h9, 1'b0, 1'b0};
        vecs[6]  = '{7'h00, 30, 1, 4'h9, 1'b0, 1'b1};
        vecs[7]  = '{7'h77, 30, 1, 4'hA, 1'b1, 1'b0};
        vecs[8]  = '{7'h06, STABLE - 1, 0, 4'hA, 1'b1, 1'b0};
        vecs[9]  = '{7'h77, 30, 0, 4'hA, 1'b1, 1'b0};
        vecs[10] = '{7'h3F, 30, 1, 4'h0, 1'b1, 1'b0};
        vecs[11] = '{7'h71, 30, 1, 4'hF, 1'b1, 1'b0};

        rst_n = 1'b0;
        set_pat(7'h00);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        run_cycles(40, n_upd, first);
        check("por_no_upd", 32'(n_upd), 32'd0);
        check_reset_outputs("por_idle");

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].n_upd == 1)
                exp_q.push_back({vecs[i].known, vecs[i].blank, vecs[i].hex});
            set_pat(vecs[i].pat);
            run_cycles(vecs[i].hold, n_upd, first);
            check($sformatf("v%0d_n_upd", i), 32'(n_upd), 32'(vecs[i].n_upd));
            if (vecs[i].n_upd == 1)
                check($sformatf("v%0d_upd_cycle", i), 32'(first), 32'(UPD_CYC));
            check($sformatf("v%0d_hex", i),   32'(hex),   32'(vecs[i].hex));
            check($sformatf("v%0d_known", i), 32'(known), 32'(vecs[i].known));
            check($sformatf("v%0d_blank", i), 32'(blank), 32'(vecs[i].blank));
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // reset mid-SETTLE discards the candidate and clears the outputs at once
        set_pat(7'h77);
        run_cycles(10, n_upd, first);
        check("pre_rst_state", 32'(state_dbg), 32'(SETTLE));
        check("pre_rst_hex", 32'(hex), 32'hF);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_settle_rst");
        set_pat(7'h00);
        run_cycles(3, n_upd, first);
        check("in_rst_no_upd", 32'(n_upd), 32'd0);
        rst_n = 1'b1;
        run_cycles(40, n_upd, first);
        check("post_rst_no_upd", 32'(n_upd), 32'd0);
        check_reset_outputs("post_rst");

        // reset landing in the COMMIT cycle also leaves no trace
        set_pat(7'h4F);
        run_cycles(UPD_CYC - 1, n_upd, first);
        check("pre_commit_no_upd", 32'(n_upd), 32'd0);
        @(posedge clk);
        #1;
        check("commit_state", 32'(state_dbg), 32'(COMMIT));
        check("commit_upd", 32'(upd), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_commit_rst");
        set_pat(7'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(40, n_upd, first);
        check("post_commit_rst_no_upd", 32'(n_upd), 32'd0);
        check_reset_outputs("post_commit_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
